// File: rtl/chenillard_led_out.sv
// rtl/chenillard_led_out.sv - Avalon-MM LED output port with prescaled chaser/bounce stepping
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[2:0]          register select (0 DATA, 1 CTRL, 2 PERIOD, 3 STATUS,
//                         4 OUTSET, 5 OUTCLR, 6/7 reserved)
//   chipselect, write_n   slave select and active-low write strobe
//   writedata[31:0]       write data
//   readdata[31:0]        registered read data, one clock after address
//   irq                   level interrupt = WRAP & IRQ_EN
//   out_port[WIDTH-1:0]   LED drive
//
// Macro CHENILLARD_LED_ACTIVE_LOW_EN: when defined, out_port drives the
// inverted LED register; DATA readback stays non-inverted.

module chenillard_led_out #(
  parameter int          WIDTH         = 10,
  parameter int          PRESC_W       = 26,
  parameter logic [31:0] RESET_PATTERN = 32'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] LP_RST_LED = RESET_PATTERN[WIDTH-1:0];

  logic [WIDTH-1:0]   r_led;
  logic               r_run;
  logic               r_dir;
  logic               r_bounce;
  logic               r_irq_en;
  logic [PRESC_W-1:0] r_period;
  logic [PRESC_W-1:0] r_count;
  logic               r_wrap;
  logic [31:0]        r_readdata;

  logic               w_wr;
  logic               w_wr_data;
  logic               w_wr_ctrl;
  logic               w_wr_period;
  logic               w_wr_status;
  logic               w_wr_set;
  logic               w_wr_clr;
  logic               w_tick;
  logic               w_step_en;
  logic [WIDTH-1:0]   w_step_led;
  logic               w_step_dir;
  logic               w_step_wrap;
  logic [31:0]        w_rdata;
  logic               w_unused_wdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_data   = w_wr & (address == 3'd0);
  assign w_wr_ctrl   = w_wr & (address == 3'd1);
  assign w_wr_period = w_wr & (address == 3'd2);
  assign w_wr_status = w_wr & (address == 3'd3);
  assign w_wr_set    = w_wr & (address == 3'd4);
  assign w_wr_clr    = w_wr & (address == 3'd5);

  // Upper writedata bits are only meaningful for some registers.
  assign w_unused_wdata = &{1'b0, writedata};

  assign w_tick = r_run & (r_count == '0);

  // Any CPU update of the pattern in a tick cycle discards that step,
  // including its wrap event.
  assign w_step_en = w_tick & ~(w_wr_data | w_wr_set | w_wr_clr);

  // Next pattern for one step. A zero pattern never has a set wrapping bit,
  // so it stays zero without raising a wrap event.
  always_comb begin
    w_step_led  = r_led;
    w_step_dir  = r_dir;
    w_step_wrap = 1'b0;
    if (!r_bounce) begin
      if (!r_dir) begin
        w_step_led  = (r_led << 1) | (r_led >> (WIDTH - 1));
        w_step_wrap = r_led[WIDTH-1];
      end else begin
        w_step_led  = (r_led >> 1) | (r_led << (WIDTH - 1));
        w_step_wrap = r_led[0];
      end
    end else begin
      if (!r_dir) begin
        if (r_led[WIDTH-1]) begin
          // Reverse at the top: this very step already moves right.
          w_step_led  = r_led >> 1;
          w_step_dir  = 1'b1;
          w_step_wrap = 1'b1;
        end else begin
          w_step_led = r_led << 1;
        end
      end else begin
        if (r_led[0]) begin
          w_step_led  = r_led << 1;
          w_step_dir  = 1'b0;
          w_step_wrap = 1'b1;
        end else begin
          w_step_led = r_led >> 1;
        end
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (address)
      3'd0:    w_rdata = 32'(r_led);
      3'd1:    w_rdata = {28'd0, r_irq_en, r_bounce, r_dir, r_run};
      3'd2:    w_rdata = 32'(r_period);
      3'd3:    w_rdata = {30'd0, r_run, r_wrap};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= LP_RST_LED;
    end else if (w_wr_data) begin
      r_led <= writedata[WIDTH-1:0];
    end else if (w_wr_set) begin
      r_led <= r_led | writedata[WIDTH-1:0];
    end else if (w_wr_clr) begin
      r_led <= r_led & ~writedata[WIDTH-1:0];
    end else if (w_step_en) begin
      r_led <= w_step_led;
    end
  end

  // A CTRL write overrides the bounce reversal, but the step itself
  // still happens with the pre-write mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_dir    <= 1'b0;
      r_bounce <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_run    <= writedata[0];
      r_dir    <= writedata[1];
      r_bounce <= writedata[2];
      r_irq_en <= writedata[3];
    end else if (w_step_en) begin
      r_dir <= w_step_dir;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_period) begin
        r_period <= writedata[PRESC_W-1:0];
        r_count  <= writedata[PRESC_W-1:0];
      end else if (!r_run || r_count == '0) begin
        r_count <= r_period;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Setting beats clearing so a wrap coinciding with a STATUS write is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap <= 1'b0;
    end else if (w_step_en && w_step_wrap) begin
      r_wrap <= 1'b1;
    end else if (w_wr_status) begin
      r_wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_wrap & r_irq_en;

`ifdef CHENILLARD_LED_ACTIVE_LOW_EN
  assign out_port = ~r_led;
`else
  assign out_port = r_led;
`endif

endmodule

// File: tb/tb_chenillard_led_out.sv
// tb/tb_chenillard_led_out.sv - directed self-checking bench for chenillard_led_out

module tb_chenillard_led_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [9:0]  out_port;

  int errors;
  int checks;

  chenillard_led_out dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] exp_out(input logic [9:0] v);
`ifdef CHENILLARD_LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the next negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  // Called at a negedge; returns readdata one clock after the address.
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #12;
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL reset_out out_port=%h expected %h", out_port, exp_out(10'h001)); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq irq=%b expected 0", irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata readdata=%h expected 0", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, d);
    checks++; if (d !== 32'h001) begin errors++; $display("FAIL reset_data_read got=%h expected 001", d); end
    rd(3'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl_read got=%h expected 0", d); end
    rd(3'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_period_read got=%h expected 0", d); end
    rd(3'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status_read got=%h expected 0", d); end
  endtask

  task automatic test_direct;
    logic [31:0] d;
    wr(3'd0, 32'h0F0);
    checks++; if (out_port !== exp_out(10'h0F0)) begin errors++; $display("FAIL direct_data out_port=%h expected %h", out_port, exp_out(10'h0F0)); end
    wr(3'd4, 32'h003);
    checks++; if (out_port !== exp_out(10'h0F3)) begin errors++; $display("FAIL direct_outset out_port=%h expected %h", out_port, exp_out(10'h0F3)); end
    wr(3'd5, 32'h030);
    checks++; if (out_port !== exp_out(10'h0C3)) begin errors++; $display("FAIL direct_outclr out_port=%h expected %h", out_port, exp_out(10'h0C3)); end
    rd(3'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL direct_outset_read got=%h expected 0", d); end
    rd(3'd5, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL direct_outclr_read got=%h expected 0", d); end
    rd(3'd0, d);
    checks++; if (d !== 32'h0C3) begin errors++; $display("FAIL direct_data_read got=%h expected 0c3", d); end
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved6_read got=%h expected 0", d); end
    rd(3'd7, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved7_read got=%h expected 0", d); end
    checks++; if (out_port !== exp_out(10'h0C3)) begin errors++; $display("FAIL reserved_write out_port=%h expected %h", out_port, exp_out(10'h0C3)); end
    wr(3'd0, 32'hFFFF_FC00);
    rd(3'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL data_upper_bits got=%h expected 0", d); end
  endtask

  task automatic test_prescaler;
    logic [31:0] d;
    wr(3'd2, 32'd3);
    rd(3'd2, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL period_read got=%h expected 3", d); end
    wr(3'd0, 32'h200);
    wr(3'd1, 32'h9);
    checks++; if (out_port !== exp_out(10'h200)) begin errors++; $display("FAIL presc_start out_port=%h expected %h", out_port, exp_out(10'h200)); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (out_port !== exp_out(10'h200)) begin errors++; $display("FAIL presc_hold%0d out_port=%h expected %h", i, out_port, exp_out(10'h200)); end
    end
    @(negedge clk);
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL presc_step1 out_port=%h expected %h", out_port, exp_out(10'h001)); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL presc_irq irq=%b expected 1", irq); end
    for (int i = 5; i <= 7; i++) begin
      @(negedge clk);
      checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL presc_hold%0d out_port=%h expected %h", i, out_port, exp_out(10'h001)); end
    end
    @(negedge clk);
    checks++; if (out_port !== exp_out(10'h002)) begin errors++; $display("FAIL presc_step2 out_port=%h expected %h", out_port, exp_out(10'h002)); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL presc_irq_sticky irq=%b expected 1", irq); end
    wr(3'd3, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL presc_irq_clear irq=%b expected 0", irq); end
    wr(3'd1, 32'd0);
  endtask

  task automatic test_rotate_right;
    logic [31:0] d;
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h001);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'h3);
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL rotr_start out_port=%h expected %h", out_port, exp_out(10'h001)); end
    @(negedge clk);
    checks++; if (out_port !== exp_out(10'h200)) begin errors++; $display("FAIL rotr_wrap out_port=%h expected %h", out_port, exp_out(10'h200)); end
    @(negedge clk);
    checks++; if (out_port !== exp_out(10'h100)) begin errors++; $display("FAIL rotr_step out_port=%h expected %h", out_port, exp_out(10'h100)); end
    wr(3'd1, 32'd0);
    rd(3'd3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rotr_status got=%h expected 1", d); end
  endtask

  task automatic test_bounce;
    logic [31:0] d;
    logic [9:0]  e;
    wr(3'd3, 32'd0);
    wr(3'd0, 32'h001);
    wr(3'd1, 32'h5);
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL bounce_start out_port=%h expected %h", out_port, exp_out(10'h001)); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = 10'(1 << k);
      checks++; if (out_port !== exp_out(e)) begin errors++; $display("FAIL bounce_step%0d out_port=%h expected %h", k, out_port, exp_out(e)); end
    end
    @(negedge clk);
    checks++; if (out_port !== exp_out(10'h100)) begin errors++; $display("FAIL bounce_reverse out_port=%h expected %h", out_port, exp_out(10'h100)); end
    rd(3'd1, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL bounce_ctrl_dir got=%h expected 7", d); end
    rd(3'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL bounce_status got=%h expected 3", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq_masked irq=%b expected 0", irq); end
    wr(3'd1, 32'd0);
  endtask

  task automatic test_priority;
    logic [31:0] d;
    wr(3'd3, 32'd0);
    wr(3'd0, 32'h001);
    wr(3'd1, 32'h1);
    wr(3'd0, 32'h055);
    checks++; if (out_port !== exp_out(10'h055)) begin errors++; $display("FAIL prio_data_wins out_port=%h expected %h", out_port, exp_out(10'h055)); end
    wr(3'd3, 32'd0);
    rd(3'd3, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL prio_status_cleared got=%h expected 2", d); end
    wr(3'd0, 32'h200);
    wr(3'd3, 32'd0);
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL prio_wrap_step out_port=%h expected %h", out_port, exp_out(10'h001)); end
    rd(3'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL prio_set_wins got=%h expected 3", d); end
    wr(3'd1, 32'd0);
    // CTRL write in a reversing tick: written DIR=0 must win over the toggle.
    wr(3'd0, 32'h200);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'h5);
    wr(3'd1, 32'h5);
    checks++; if (out_port !== exp_out(10'h100)) begin errors++; $display("FAIL prio_ctrl_step out_port=%h expected %h", out_port, exp_out(10'h100)); end
    rd(3'd1, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL prio_ctrl_dir_wins got=%h expected 5", d); end
    wr(3'd1, 32'd0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'hB);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL areset_out out_port=%h expected %h", out_port, exp_out(10'h001)); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL areset_readdata readdata=%h expected 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq irq=%b expected 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (out_port !== exp_out(10'h001)) begin errors++; $display("FAIL areset_no_step out_port=%h expected %h", out_port, exp_out(10'h001)); end
    rd(3'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL areset_ctrl got=%h expected 0", d); end
`ifdef CHENILLARD_LED_ACTIVE_LOW_EN
    wr(3'd0, 32'h00F);
    checks++; if (out_port !== 10'h3F0) begin errors++; $display("FAIL actlow_out out_port=%h expected 3f0", out_port); end
    rd(3'd0, d);
    checks++; if (d !== 32'h00F) begin errors++; $display("FAIL actlow_data_read got=%h expected 00f", d); end
`endif
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    test_reset();
    test_direct();
    test_prescaler();
    test_rotate_right();
    test_bounce();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
